// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage register file with run statistics.
// Two combinational operand read ports (A/B) for ID, one debug read port,
// a sticky halt flag, and saturating cycle / register-write counters that
// freeze once halted.
// Optional feature macro: WB_BYPASS_EN -- when defined, a write being committed
// this cycle is forwarded straight onto A_o/B_o (write-through). dbg_data_o is
// never bypassed.

module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt_i,
  input  logic              Regwrite_i,
  input  logic [ADDR_W-1:0] rw_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic [ADDR_W-1:0] ra_i,
  input  logic [ADDR_W-1:0] rb_i,
  output logic [DATA_W-1:0] A_o,
  output logic [DATA_W-1:0] B_o,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  output logic [DATA_W-1:0] dbg_data_o,
  output logic              halted_o,
  output logic [CNT_W-1:0]  cycle_o,
  output logic [CNT_W-1:0]  wrcnt_o
);

  localparam int                DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] IDX_ZERO  = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  logic [DATA_W-1:0] regs_r [DEPTH];
  logic              halted_r;
  logic [CNT_W-1:0]  cycle_r;
  logic [CNT_W-1:0]  wrcnt_r;
  logic              we_s;
  logic [DATA_W-1:0] a_s;
  logic [DATA_W-1:0] b_s;
  logic [DATA_W-1:0] dbg_s;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == CNT_MAX) begin
      r = v;
    end else begin
      r = v + CNT_ONE;
    end
    return r;
  endfunction

  // Register 0 is never written; halt blocks every write after the halting edge.
  assign we_s = Regwrite_i & ~halted_r & (rw_i != IDX_ZERO);

  // Register storage: cleared on reset, one write per cycle on commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_r[i] <= DATA_ZERO;
      end
    end else if (we_s) begin
      regs_r[rw_i] <= wb_data_i;
    end
  end

  // Sticky halt flag; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      halted_r <= 1'b0;
    end else if (halt_i) begin
      halted_r <= 1'b1;
    end
  end

  // Cycle counter runs while not halted, including the edge that sets halt.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_r <= CNT_ZERO;
    end else if (!halted_r) begin
      cycle_r <= sat_inc(cycle_r);
    end
  end

  // Write counter counts committed (non-$0, non-halted) writes only.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrcnt_r <= CNT_ZERO;
    end else if (we_s) begin
      wrcnt_r <= sat_inc(wrcnt_r);
    end
  end

  // Operand port A: $0 reads zero, optional write-through of the committing value.
  always_comb begin
    a_s = DATA_ZERO;
    if (ra_i == IDX_ZERO) begin
      a_s = DATA_ZERO;
`ifdef WB_BYPASS_EN
    end else if (we_s && (ra_i == rw_i)) begin
      a_s = wb_data_i;
`endif
    end else begin
      a_s = regs_r[ra_i];
    end
  end

  // Operand port B: same rules as port A.
  always_comb begin
    b_s = DATA_ZERO;
    if (rb_i == IDX_ZERO) begin
      b_s = DATA_ZERO;
`ifdef WB_BYPASS_EN
    end else if (we_s && (rb_i == rw_i)) begin
      b_s = wb_data_i;
`endif
    end else begin
      b_s = regs_r[rb_i];
    end
  end

  // Debug port always shows the stored value.
  always_comb begin
    dbg_s = DATA_ZERO;
    if (dbg_addr_i == IDX_ZERO) begin
      dbg_s = DATA_ZERO;
    end else begin
      dbg_s = regs_r[dbg_addr_i];
    end
  end

  assign A_o        = a_s;
  assign B_o        = b_s;
  assign dbg_data_o = dbg_s;
  assign halted_o   = halted_r;
  assign cycle_o    = cycle_r;
  assign wrcnt_o    = wrcnt_r;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed table, hand-written halt/reset
// sequences, and randomized traffic against a behavioural model. A second
// instance with 4-bit counters exercises counter saturation.

module tb_wb_regfile;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int CW  = 32;
  localparam int CWS = 4;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          halt_i;
  logic          Regwrite_i;
  logic [AW-1:0] rw_i, ra_i, rb_i, dbg_addr_i;
  logic [DW-1:0] wb_data_i;
  logic [DW-1:0] A_o, B_o, dbg_data_o;
  logic          halted_o;
  logic [CW-1:0] cycle_o, wrcnt_o;
  logic [DW-1:0] A_s, B_s, dbg_s;
  logic          halted_s;
  logic [CWS-1:0] cycle_s, wrcnt_s;

  wb_regfile #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .halt_i(halt_i), .Regwrite_i(Regwrite_i),
    .rw_i(rw_i), .wb_data_i(wb_data_i), .ra_i(ra_i), .rb_i(rb_i),
    .A_o(A_o), .B_o(B_o), .dbg_addr_i(dbg_addr_i), .dbg_data_o(dbg_data_o),
    .halted_o(halted_o), .cycle_o(cycle_o), .wrcnt_o(wrcnt_o)
  );

  wb_regfile #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CWS)) dut_small (
    .clk(clk), .rst(rst), .halt_i(halt_i), .Regwrite_i(Regwrite_i),
    .rw_i(rw_i), .wb_data_i(wb_data_i), .ra_i(ra_i), .rb_i(rb_i),
    .A_o(A_s), .B_o(B_s), .dbg_addr_i(dbg_addr_i), .dbg_data_o(dbg_s),
    .halted_o(halted_s), .cycle_o(cycle_s), .wrcnt_o(wrcnt_s)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // ---------------- behavioural model ----------------
  logic [DW-1:0] mregs [32];
  bit            mhalt;
  longint        mcyc, mwr, mcyc_s, mwr_s;
  localparam longint MAXB = 64'hFFFF_FFFF;
  localparam longint MAXS = 15;

  function automatic longint sat(input longint v, input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [DW-1:0] mread(input logic [AW-1:0] idx, input bit operand_port);
    logic [DW-1:0] r;
    r = (idx == 0) ? '0 : mregs[idx];
    if (BYP && operand_port && Regwrite_i && !mhalt && rw_i != 0 && idx == rw_i)
      r = wb_data_i;
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    mhalt = 1'b0; mcyc = 0; mwr = 0; mcyc_s = 0; mwr_s = 0;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_regs_out();
    check("halted_o", {63'd0, halted_o}, {63'd0, mhalt});
    check("cycle_o", {32'd0, cycle_o}, mcyc);
    check("wrcnt_o", {32'd0, wrcnt_o}, mwr);
    check("halted_sat", {63'd0, halted_s}, {63'd0, mhalt});
    check("cycle_sat", {60'd0, cycle_s}, mcyc_s);
    check("wrcnt_sat", {60'd0, wrcnt_s}, mwr_s);
  endtask

  // one clock: drive, check reads, clock edge, update model, check state
  task automatic run_cycle(input bit hi, input bit wen, input logic [AW-1:0] rw,
                           input logic [DW-1:0] d, input logic [AW-1:0] ra,
                           input logic [AW-1:0] rb, input logic [AW-1:0] dbg,
                           output logic [DW-1:0] a, output logic [DW-1:0] b,
                           output logic [DW-1:0] dd);
    bit we;
    halt_i = hi; Regwrite_i = wen; rw_i = rw; wb_data_i = d;
    ra_i = ra; rb_i = rb; dbg_addr_i = dbg;
    #1;
    a = A_o; b = B_o; dd = dbg_data_o;
    check("A_o", {32'd0, A_o}, {32'd0, mread(ra, 1'b1)});
    check("B_o", {32'd0, B_o}, {32'd0, mread(rb, 1'b1)});
    check("dbg_data_o", {32'd0, dbg_data_o}, {32'd0, mread(dbg, 1'b0)});
    @(posedge clk);
    we = wen && !mhalt && (rw != 0);
    if (we) begin
      mregs[rw] = d;
      mwr = sat(mwr + 1, MAXB);
      mwr_s = sat(mwr_s + 1, MAXS);
    end
    if (!mhalt) begin
      mcyc = sat(mcyc + 1, MAXB);
      mcyc_s = sat(mcyc_s + 1, MAXS);
    end
    if (hi) mhalt = 1'b1;
    #1;
    check_regs_out();
  endtask

  task automatic do_reset();
    rst = 1'b1; halt_i = 1'b0; Regwrite_i = 1'b0;
    @(posedge clk);
    model_clear();
    #1;
    rst = 1'b0;
    check_regs_out();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit            we;
    logic [AW-1:0] rw;
    logic [DW-1:0] d;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    logic [DW-1:0] ea;
    logic [DW-1:0] eb;
    logic [CW-1:0] ewr;
  } vec_t;

  vec_t tbl [7];
  logic [DW-1:0] a, b, dd;

  initial begin
    tbl[0] = '{1'b1, 5'd5, 32'h1234ABCD, 5'd5, 5'd0, BYP ? 32'h1234ABCD : 32'h0, 32'h0, 32'd1};
    tbl[1] = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd5, 32'h1234ABCD, 32'h1234ABCD, 32'd1};
    tbl[2] = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd5, 32'h0, 32'h1234ABCD, 32'd1};
    tbl[3] = '{1'b1, 5'd7, 32'h55,       5'd7, 5'd5, BYP ? 32'h55 : 32'h0, 32'h1234ABCD, 32'd2};
    tbl[4] = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd7, 32'h55, 32'h55, 32'd2};
    tbl[5] = '{1'b1, 5'd7, 32'h66,       5'd0, 5'd7, 32'h0, BYP ? 32'h66 : 32'h55, 32'd3};
    tbl[6] = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd5, 32'h66, 32'h1234ABCD, 32'd3};

    rst = 1'b1; halt_i = 1'b0; Regwrite_i = 1'b0; rw_i = '0; wb_data_i = '0;
    ra_i = '0; rb_i = '0; dbg_addr_i = '0;
    model_clear();

    // Reset: every index reads zero, counters and halt clear
    do_reset();
    check("rst_halted", {63'd0, halted_o}, 64'd0);
    check("rst_wrcnt", {32'd0, wrcnt_o}, 64'd0);
    for (int i = 0; i < 32; i++) begin
      run_cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i), 5'(i), a, b, dd);
      check("rst_read_A", {32'd0, a}, 64'd0);
      check("rst_read_B", {32'd0, b}, 64'd0);
      check("rst_read_dbg", {32'd0, dd}, 64'd0);
    end

    // Directed table: basic write, $0 write, same-cycle read
    do_reset();
    for (int i = 0; i < 7; i++) begin
      run_cycle(1'b0, tbl[i].we, tbl[i].rw, tbl[i].d, tbl[i].ra, tbl[i].rb, tbl[i].rw, a, b, dd);
      check("tbl_A", {32'd0, a}, {32'd0, tbl[i].ea});
      check("tbl_B", {32'd0, b}, {32'd0, tbl[i].eb});
      check("tbl_wrcnt", {32'd0, wrcnt_o}, {32'd0, tbl[i].ewr});
      check("tbl_cycle", {32'd0, cycle_o}, 64'(i + 1));
    end

    // Halt sequence: write in halt cycle commits, later write blocked
    do_reset();
    for (int i = 0; i < 10; i++)
      run_cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0, a, b, dd);
    run_cycle(1'b1, 1'b1, 5'd3, 32'd9, 5'd3, 5'd0, 5'd3, a, b, dd);
    check("halt_set", {63'd0, halted_o}, 64'd1);
    check("halt_cycle", {32'd0, cycle_o}, 64'd11);
    run_cycle(1'b0, 1'b1, 5'd4, 32'd1, 5'd4, 5'd3, 5'd4, a, b, dd);
    check("halt_blocked_A", {32'd0, a}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      run_cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd4, 5'd3, a, b, dd);
      check("halt_r3", {32'd0, a}, 64'd9);
      check("halt_r4", {32'd0, b}, 64'd0);
      check("halt_dbg", {32'd0, dd}, 64'd9);
      check("halt_cycle_hold", {32'd0, cycle_o}, 64'd11);
      check("halt_wrcnt_hold", {32'd0, wrcnt_o}, 64'd1);
      check("halt_sticky", {63'd0, halted_o}, 64'd1);
    end

    // Reset after halt clears everything; writes commit again
    do_reset();
    check("rerst_halted", {63'd0, halted_o}, 64'd0);
    check("rerst_cycle", {32'd0, cycle_o}, 64'd0);
    run_cycle(1'b0, 1'b1, 5'd4, 32'hA, 5'd3, 5'd0, 5'd3, a, b, dd);
    check("rerst_r3", {32'd0, a}, 64'd0);
    run_cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd4, 5'd0, 5'd4, a, b, dd);
    check("rerst_r4", {32'd0, a}, 64'hA);
    check("rerst_wrcnt", {32'd0, wrcnt_o}, 64'd1);

    // Randomized traffic with occasional halts and mid-run resets
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic [AW-1:0] rw, ra, rb;
      rw = 5'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? rw : 5'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? rw : 5'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        run_cycle($urandom_range(0, 399) == 0, 1'($urandom), rw, $urandom,
                  ra, rb, 5'($urandom), a, b, dd);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
